// File: rtl/ysyx_22050710_div_seq.sv
// Iterative restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// Produces one quotient bit per cycle. Divide-by-zero and signed overflow finish right after accept.
module ysyx_22050710_div_seq #(
  parameter int WORD_WD = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [1:0]         i_op,
  input  logic               i_word,
  input  logic [WORD_WD-1:0] i_src_a,
  input  logic [WORD_WD-1:0] i_src_b,
  input  logic               i_flush,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WORD_WD-1:0] o_result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [WORD_WD-1:0] rem, quo, dvs;
  logic [6:0]         cnt;
  logic               neg_q, neg_r, sel_rem, word;

  logic               is_signed, b_zero, ovf;
  logic [WORD_WD-1:0] a_ext, b_ext, a_mag, b_mag, spec_raw, spec_res;
  logic [WORD_WD:0]   partial;
  logic               fits;
  logic [WORD_WD-1:0] diff, rem_nxt, quo_nxt, res_raw, res_sgn, fin;

  // Operand preparation and special-case detection for the request at the input
  always_comb begin
    is_signed = ~i_op[0];
    if (i_word) begin
      a_ext = is_signed ? {{32{i_src_a[31]}}, i_src_a[31:0]} : {32'b0, i_src_a[31:0]};
      b_ext = is_signed ? {{32{i_src_b[31]}}, i_src_b[31:0]} : {32'b0, i_src_b[31:0]};
    end else begin
      a_ext = i_src_a;
      b_ext = i_src_b;
    end
    a_mag  = (is_signed && a_ext[WORD_WD-1]) ? -a_ext : a_ext;
    b_mag  = (is_signed && b_ext[WORD_WD-1]) ? -b_ext : b_ext;
    b_zero = (b_ext == '0);
    ovf    = is_signed && (b_ext == '1) &&
             (i_word ? (a_ext == {{(WORD_WD-31){1'b1}}, 31'b0})
                     : (a_ext == {1'b1, {(WORD_WD-1){1'b0}}}));
    if (b_zero) spec_raw = i_op[1] ? a_ext : '1;
    else        spec_raw = i_op[1] ? '0 : a_ext;
    spec_res = i_word ? {{32{spec_raw[31]}}, spec_raw[31:0]} : spec_raw;
  end

  // One restoring step, plus sign fix-up of the value that will be latched on the last step
  always_comb begin
    partial = {rem, quo[WORD_WD-1]};
    fits    = (partial >= {1'b0, dvs});
    diff    = partial[WORD_WD-1:0] - dvs;
    rem_nxt = fits ? diff : partial[WORD_WD-1:0];
    quo_nxt = {quo[WORD_WD-2:0], fits};
    res_raw = sel_rem ? rem_nxt : quo_nxt;
    res_sgn = (sel_rem ? neg_r : neg_q) ? -res_raw : res_raw;
    fin     = word ? {{32{res_sgn[31]}}, res_sgn[31:0]} : res_sgn;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      o_valid  <= 1'b0;
      o_ready  <= 1'b1;
      o_result <= '0;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      sel_rem  <= 1'b0;
      word     <= 1'b0;
    end else if (i_flush) begin
      state   <= IDLE;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid && o_ready) begin
            o_ready <= 1'b0;
            sel_rem <= i_op[1];
            word    <= i_word;
            neg_q   <= is_signed & (a_ext[WORD_WD-1] ^ b_ext[WORD_WD-1]);
            neg_r   <= is_signed & a_ext[WORD_WD-1];
            if (b_zero || ovf) begin
              o_result <= spec_res;
              o_valid  <= 1'b1;
              state    <= DONE;
            end else begin
              // Word dividends sit in the upper half so 32 shifts consume exactly their bits
              rem   <= '0;
              quo   <= i_word ? {a_mag[31:0], 32'b0} : a_mag;
              dvs   <= b_mag;
              cnt   <= i_word ? 7'd32 : 7'd64;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt - 7'd1;
          if (cnt == 7'd1) begin
            o_result <= fin;
            o_valid  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050710_div_seq.sv
// Directed bench for ysyx_22050710_div_seq: result values, latency, backpressure, flush and reset.
module tb_ysyx_22050710_div_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, word, flush, out_valid, in_ready;
  logic [1:0]  op;
  logic [63:0] src_a, src_b, result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_22050710_div_seq #(.WORD_WD(64)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (in_valid),
    .o_ready (out_ready),
    .i_op    (op),
    .i_word  (word),
    .i_src_a (src_a),
    .i_src_b (src_b),
    .i_flush (flush),
    .o_valid (out_valid),
    .i_ready (in_ready),
    .o_result(result)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] o, input logic w, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    in_valid = 1'b1; op = o; word = w; src_a = a; src_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Issue one op, measure cycles from accept edge to o_valid, optionally stall, then consume
  task automatic run(input string tag, input logic [1:0] o, input logic w,
                     input logic [63:0] a, input logic [63:0] b,
                     input int exp_lat, input logic [63:0] exp_res, input int hold);
    int lat;
    chk({tag, "_ready_before"}, 64'(out_ready), 64'd1);
    drive(o, w, a, b);
    chk({tag, "_busy"}, 64'(out_ready), 64'd0);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, result, exp_res);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk($sformatf("%s_hold_valid%0d", tag, i), 64'(out_valid), 64'd1);
      chk($sformatf("%s_hold_res%0d", tag, i), result, exp_res);
    end
    in_ready = 1'b1;
    @(posedge clk); #1;
    in_ready = 1'b0;
    chk({tag, "_done_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_done_ready"}, 64'(out_ready), 64'd1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; op = 2'b00; word = 1'b0; src_a = '0; src_b = '0;
    flush = 1'b0; in_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", 64'(out_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);

    run("div_64",    2'b00, 1'b0, -64'sd7, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run("rem_64",    2'b10, 1'b0, -64'sd7, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run("divu_64",   2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 65, 64'h0FFF_FFFF_FFFF_FFFF, 0);
    run("remu_64",   2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 65, 64'hF, 0);
    run("divu_z",    2'b01, 1'b0, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run("rem_z",     2'b10, 1'b0, -64'sd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFB, 0);
    run("div_ovf",   2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h8000_0000_0000_0000, 0);
    run("rem_ovf",   2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0, 0);
    run("divw_ovf",  2'b00, 1'b1, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF, 1, 64'hFFFF_FFFF_8000_0000, 0);
    run("divuw",     2'b01, 1'b1, 64'hFFFF_FFFF_0000_0010, 64'd3, 33, 64'd5, 0);
    run("remw",      2'b10, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run("divuw_sx",  2'b01, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 33, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run("remuw_z",   2'b11, 1'b1, 64'hABCD_0000_8000_0001, 64'hFFFF_0000_0000_0000, 1, 64'hFFFF_FFFF_8000_0001, 0);
    run("div_stall", 2'b00, 1'b0, 64'd100, 64'd7, 65, 64'd14, 10);

    // Flush during CALC at T+10
    drive(2'b00, 1'b0, 64'd1000, 64'd3);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_calc_ready", 64'(out_ready), 64'd1);
    chk("flush_calc_valid", 64'(out_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("flush_calc_never_valid", 64'(seen), 64'd0);

    // Flush alongside a request in IDLE: must not be accepted
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = 2'b01; word = 1'b0; src_a = 64'd5; src_b = 64'd0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_ready", 64'(out_ready), 64'd1);
    chk("flush_idle_valid", 64'(out_valid), 64'd0);

    // Flush beats i_ready in DONE
    drive(2'b01, 1'b0, 64'd5, 64'd0);
    chk("flush_done_pre", 64'(out_valid), 64'd1);
    flush = 1'b1; in_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_ready = 1'b0;
    chk("flush_done_valid", 64'(out_valid), 64'd0);
    chk("flush_done_ready", 64'(out_ready), 64'd1);

    // Reset at T+20 during CALC; o_result is nonzero beforehand
    drive(2'b00, 1'b0, 64'd77, 64'd5);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_ready", 64'(out_ready), 64'd1);
    chk("rst_mid_result", result, 64'd0);
    chk("rst_mid_valid", 64'(out_valid), 64'd0);

    run("post_rst", 2'b11, 1'b0, 64'd77, 64'd5, 65, 64'd2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
